// File: rtl/dshot_pwm_output.sv
// Purpose: turn accepted DShot frames into a servo/ESC PWM pulse train, with a failsafe timeout.
// Latency: outputs registered; an accepted frame in S_SAFE raises pwm_out on the sampling edge.
// Backpressure: none; every frame_done strobe is consumed in the cycle it is presented.
// Optional: DSHOT_PWM_CRC_ERR_COUNT_EN adds a saturating crc_err_count output.
module dshot_pwm_output #(
  parameter int CLK_FREQ_HZ  = 16000000,
  parameter int PERIOD_US    = 2500,
  parameter int MIN_PULSE_US = 1000,
  parameter int FAILSAFE_MS  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done,
  input  logic        frame_crc_ok,
  input  logic [10:0] speed_in,
  input  logic        speed_is_throttle,
  output logic        pwm_out,
  output logic        armed,
  output logic        failsafe,
  output logic [10:0] pulse_us,
  output logic        frame_accepted
`ifdef DSHOT_PWM_CRC_ERR_COUNT_EN
  ,
  output logic [7:0]  crc_err_count
`endif
);

  localparam int TICKS_PER_US = CLK_FREQ_HZ / 1000000;
  localparam int PERIOD_TICKS = PERIOD_US * TICKS_PER_US;
  localparam int FS_TICKS     = FAILSAFE_MS * 1000 * TICKS_PER_US;

  typedef enum logic [1:0] {S_SAFE, S_HIGH, S_LOW} state_t;

  state_t      state, state_nxt;
  logic [15:0] period_cnt, period_cnt_nxt;
  logic [10:0] pending_us, pending_nxt;
  logic [10:0] applied_us, applied_nxt;
  logic [10:0] pulse_nxt;
  logic        pwm_nxt, armed_nxt;
  logic [23:0] fs_cnt;
  logic        accept;
  logic [10:0] spd_off;
  logic [21:0] prod;
  logic [15:0] high_ticks;

  assign accept     = frame_done & frame_crc_ok;
  assign spd_off    = speed_in - 11'd48;
  // 48..2047 spans 2000 steps; x1025/2048 lands exactly on +0..+1000 us
  assign prod       = {11'd0, spd_off} * 22'd1025;
  assign high_ticks = {5'd0, applied_us} * 16'(TICKS_PER_US);

  // Width the next pulse will use, including a frame landing on this very edge
  always_comb begin
    pending_nxt = pending_us;
    if (accept) begin
      if (speed_is_throttle) begin
        pending_nxt = 11'(MIN_PULSE_US) + 11'(prod >> 11);
      end else if (speed_in == 11'd0) begin
        pending_nxt = 11'(MIN_PULSE_US);
      end
    end
  end

  // Next-state and output decode; widths only change at a period boundary
  always_comb begin
    state_nxt      = state;
    pwm_nxt        = pwm_out;
    armed_nxt      = armed;
    pulse_nxt      = pulse_us;
    applied_nxt    = applied_us;
    period_cnt_nxt = period_cnt + 16'd1;
    case (state)
      S_SAFE: begin
        period_cnt_nxt = '0;
        pwm_nxt        = 1'b0;
        armed_nxt      = 1'b0;
        if (accept) begin
          state_nxt   = S_HIGH;
          pwm_nxt     = 1'b1;
          armed_nxt   = 1'b1;
          applied_nxt = pending_nxt;
          pulse_nxt   = pending_nxt;
        end
      end
      S_HIGH: begin
        if (period_cnt == high_ticks - 16'd1) begin
          state_nxt = S_LOW;
          pwm_nxt   = 1'b0;
        end
      end
      S_LOW: begin
        if (period_cnt == 16'(PERIOD_TICKS - 1)) begin
          period_cnt_nxt = '0;
          // a frame on the boundary edge also clears failsafe, so it keeps us armed
          if (failsafe && !accept) begin
            state_nxt = S_SAFE;
            armed_nxt = 1'b0;
            pulse_nxt = '0;
            pwm_nxt   = 1'b0;
          end else begin
            state_nxt   = S_HIGH;
            pwm_nxt     = 1'b1;
            applied_nxt = pending_nxt;
            pulse_nxt   = pending_nxt;
          end
        end
      end
      default: begin
        state_nxt = S_SAFE;
        pwm_nxt   = 1'b0;
        armed_nxt = 1'b0;
        pulse_nxt = '0;
      end
    endcase
  end

  // FSM state and registered PWM outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_SAFE;
      pwm_out    <= 1'b0;
      armed      <= 1'b0;
      pulse_us   <= '0;
      applied_us <= '0;
      period_cnt <= '0;
      pending_us <= 11'(MIN_PULSE_US);
    end else begin
      state      <= state_nxt;
      pwm_out    <= pwm_nxt;
      armed      <= armed_nxt;
      pulse_us   <= pulse_nxt;
      applied_us <= applied_nxt;
      period_cnt <= period_cnt_nxt;
      pending_us <= pending_nxt;
    end
  end

  // Failsafe timer: saturating count since the last accepted frame; a frame beats a trip
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs_cnt         <= '0;
      failsafe       <= 1'b0;
      frame_accepted <= 1'b0;
    end else begin
      frame_accepted <= accept;
      if (accept) begin
        fs_cnt   <= '0;
        failsafe <= 1'b0;
      end else if (fs_cnt == 24'(FS_TICKS - 1)) begin
        failsafe <= 1'b1;
      end else begin
        fs_cnt <= fs_cnt + 24'd1;
      end
    end
  end

`ifdef DSHOT_PWM_CRC_ERR_COUNT_EN
  // Saturating count of CRC-failed frames since the last accepted one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_err_count <= '0;
    end else if (accept) begin
      crc_err_count <= '0;
    end else if (frame_done && !frame_crc_ok && crc_err_count != 8'hFF) begin
      crc_err_count <= crc_err_count + 8'd1;
    end
  end
`endif

endmodule
